// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if.sv
// Channel-side bundle for the debounced NOR: the sample enable and input slices going in,
// the registered NOR, the change pulses and the per-channel debounce counters coming out.
interface gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if #(
  parameter int NCH  = 4,
  parameter int NIN  = 2,
  parameter int DCNT = 3
);
  localparam int CW = $clog2(DCNT + 1);

  // EN and A have no handshake. They are sampled on every rising clock edge and must be
  // stable around it. ZN and CHG are registered and valid for the whole cycle after the edge.
  logic                EN;
  logic [NCH*NIN-1:0]  A;
  logic [NCH-1:0]      ZN;
  logic [NCH-1:0]      CHG;
  logic [NCH*CW-1:0]   cnt_dbg;

  modport master (output EN, output A, input ZN, input CHG, input cnt_dbg);
  modport slave  (input EN, input A, output ZN, output CHG, output cnt_dbg);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_dbnc.sv
// Multi-channel NIN-input NOR. Each channel's registered output follows its raw NOR only
// after the NOR has differed from the output for DCNT consecutive enabled clocks.
module gf180mcu_fd_sc_mcu7t5v0__nor_dbnc #(
  parameter int NCH  = 4,
  parameter int NIN  = 2,
  parameter int DCNT = 3
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if.slave bus
);
  localparam int CW = $clog2(DCNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DCNT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ch_state_e;

  logic [NCH-1:0]         raw;
  logic [NCH-1:0]         zn_q, zn_d;
  logic [NCH-1:0]         chg_q, chg_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  ch_state_e              state [NCH];

  // The supply pins carry no logic; they are only referenced to keep them attached.
  wire unused_rails = VDD ^ VSS;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      raw[k]   = ~|bus.A[k*NIN +: NIN];
      state[k] = (cnt_q[k] == '0) ? ST_IDLE : ST_PEND;
    end
  end

  always_comb begin
    zn_d  = zn_q;
    chg_d = '0;
    cnt_d = cnt_q;
    if (bus.EN) begin
      for (int k = 0; k < NCH; k++) begin
        case (state[k])
          ST_IDLE: begin
            if (raw[k] != zn_q[k]) begin
              if (LAST == '0) begin
                zn_d[k]  = raw[k];
                chg_d[k] = 1'b1;
              end else begin
                cnt_d[k] = CW'(1);
              end
            end
          end
          ST_PEND: begin
            // A mismatch that disappears before the count completes is a glitch: drop it.
            if (raw[k] == zn_q[k]) begin
              cnt_d[k] = '0;
            end else if (cnt_q[k] == LAST) begin
              zn_d[k]  = raw[k];
              chg_d[k] = 1'b1;
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
          default: cnt_d[k] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      zn_q  <= '1;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      zn_q  <= zn_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ZN      = zn_q;
  assign bus.CHG     = chg_q;
  assign bus.cnt_dbg = cnt_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor_dbnc.sv
// Bench for the debounced NOR: directed scenarios on the default 4x2 / DCNT=3 instance,
// then a randomized run on three parameterisations against a timestamp-based model.
module tb_gf180mcu_fd_sc_mcu7t5v0__nor_dbnc;
  logic clk;
  logic rst;
  wire  vdd_w = 1'b1;
  wire  vss_w = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if #(.NCH(4), .NIN(2), .DCNT(3)) if0 ();
  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if #(.NCH(1), .NIN(2), .DCNT(1)) if1 ();
  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc_if #(.NCH(8), .NIN(4), .DCNT(7)) if2 ();

  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc #(.NCH(4), .NIN(2), .DCNT(3)) dut0 (
    .CLK(clk), .RST(rst), .VDD(vdd_w), .VSS(vss_w), .bus(if0));
  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc #(.NCH(1), .NIN(2), .DCNT(1)) dut1 (
    .CLK(clk), .RST(rst), .VDD(vdd_w), .VSS(vss_w), .bus(if1));
  gf180mcu_fd_sc_mcu7t5v0__nor_dbnc #(.NCH(8), .NIN(4), .DCNT(7)) dut2 (
    .CLK(clk), .RST(rst), .VDD(vdd_w), .VSS(vss_w), .bus(if2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel toggles once DCNT enabled edges have elapsed since the last
  // enabled edge at which its NOR agreed with its output (or since reset / the last toggle).
  int       m_nch  [3] = '{4, 1, 8};
  int       m_nin  [3] = '{2, 2, 4};
  int       m_dcnt [3] = '{3, 1, 7};
  int       en_idx [3];
  int       since  [3][8];
  logic [7:0] m_zn  [3];
  logic [7:0] m_chg [3];

  function automatic logic [7:0] ch_mask(int m);
    return 8'((16'd1 << m_nch[m]) - 16'd1);
  endfunction

  task automatic model_edge(input int m, input logic [31:0] a, input logic r, input logic e);
    logic raw;
    if (r) begin
      m_zn[m]  = ch_mask(m);
      m_chg[m] = '0;
      for (int c = 0; c < 8; c++) since[m][c] = en_idx[m];
    end else if (!e) begin
      m_chg[m] = '0;
    end else begin
      en_idx[m]++;
      m_chg[m] = '0;
      for (int c = 0; c < m_nch[m]; c++) begin
        raw = (((a >> (c * m_nin[m])) & ((32'd1 << m_nin[m]) - 32'd1)) == 32'd0);
        if (raw == m_zn[m][c]) begin
          since[m][c] = en_idx[m];
        end else if (en_idx[m] - since[m][c] == m_dcnt[m]) begin
          m_zn[m][c]  = raw;
          m_chg[m][c] = 1'b1;
          since[m][c] = en_idx[m];
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      en_idx[m] = 0;
      m_zn[m]   = ch_mask(m);
      m_chg[m]  = '0;
      for (int c = 0; c < 8; c++) since[m][c] = 0;
    end
  end

  always @(posedge clk) begin
    model_edge(0, 32'(if0.A), rst, if0.EN);
    model_edge(1, 32'(if1.A), rst, if1.EN);
    model_edge(2, 32'(if2.A), rst, if2.EN);
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_all(input logic [31:0] a1, input logic [31:0] a2);
    if1.A = a1[1:0];
    if2.A = a2;
  endtask

  task automatic check0(input string tag, input logic [3:0] zn, input logic [3:0] chg);
    check_eq({tag, "_zn"},  64'(if0.ZN),  64'(zn));
    check_eq({tag, "_chg"}, 64'(if0.CHG), 64'(chg));
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    rst    = 1'b1;
    if0.EN = 1'b1; if1.EN = 1'b1; if2.EN = 1'b1;
    if0.A  = 8'($urandom);
    drive_all($urandom, $urandom);
    step(2);
    check0("reset", 4'hF, 4'h0);
    check_eq("reset_cnt", 64'(if0.cnt_dbg), 64'd0);
    rst   = 1'b0;
    if0.A = '0;
    drive_all(0, 0);
    step();
    check0("post_reset", 4'hF, 4'h0);

    // debounce on channel 0
    if0.A = 8'b0000_0001;
    step();  check0("dbnc_e1", 4'hF, 4'h0);
    step();  check0("dbnc_e2", 4'hF, 4'h0);
    step();  check0("dbnc_e3", 4'hE, 4'h1);
    step();  check0("dbnc_e4", 4'hE, 4'h0);
    if0.A = '0;
    step(2); check0("dbnc_back2", 4'hE, 4'h0);
    step();  check0("dbnc_back3", 4'hF, 4'h1);

    // glitch on channel 1
    if0.A = 8'b0000_0100;
    step(2);
    check_eq("glitch_cnt2", 64'(if0.cnt_dbg[3:2]), 64'd2);
    check0("glitch_hold", 4'hF, 4'h0);
    if0.A = '0;
    step();
    check_eq("glitch_cnt0", 64'(if0.cnt_dbg[3:2]), 64'd0);
    check0("glitch_drop", 4'hF, 4'h0);
    step(3); check0("glitch_after", 4'hF, 4'h0);

    // enable pause on channel 2
    if0.A = 8'b0001_0000;
    step();
    if0.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check0("pause_hold", 4'hF, 4'h0);
    end
    check_eq("pause_cnt", 64'(if0.cnt_dbg[5:4]), 64'd1);
    if0.EN = 1'b1;
    step();  check0("resume_e1", 4'hF, 4'h0);
    step();  check0("resume_e2", 4'hB, 4'h4);
    if0.A = '0;
    step(3); check0("resume_back", 4'hF, 4'h1 << 2);

    // reset mid-count on channel 3
    if0.A = 8'b0100_0000;
    step(2);
    check_eq("midrst_cnt2", 64'(if0.cnt_dbg[7:6]), 64'd2);
    rst = 1'b1;
    step();
    check0("midrst_edge", 4'hF, 4'h0);
    check_eq("midrst_cnt0", 64'(if0.cnt_dbg), 64'd0);
    rst = 1'b0;
    step(2); check0("midrst_e2", 4'hF, 4'h0);
    step();  check0("midrst_e3", 4'h7, 4'h8);
    step();  check0("midrst_e4", 4'h7, 4'h0);

    // randomized sweep of all three instances
    rst = 1'b1;
    step();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      // sparse input bits so the NOR stays true long enough to see debounced toggles
      if0.A  = 8'(r0 & $urandom & $urandom);
      if1.A  = 2'(r1 & $urandom);
      if2.A  = r2 & $urandom & $urandom & $urandom;
      if0.EN = ($urandom_range(0, 9) != 0);
      if1.EN = ($urandom_range(0, 9) != 0);
      if2.EN = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      step();
      check_eq("rnd0_zn",  64'(if0.ZN),  64'(m_zn[0][3:0]));
      check_eq("rnd0_chg", 64'(if0.CHG), 64'(m_chg[0][3:0]));
      check_eq("rnd1_zn",  64'(if1.ZN),  64'(m_zn[1][0]));
      check_eq("rnd1_chg", 64'(if1.CHG), 64'(m_chg[1][0]));
      check_eq("rnd2_zn",  64'(if2.ZN),  64'(m_zn[2]));
      check_eq("rnd2_chg", 64'(if2.CHG), 64'(m_chg[2]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
